// File: rtl/display_mux.sv
// ---------------------------------------------------------------------------
// display_mux
//
// Drives two seven-segment digits from one shared segment bus.
// A single seven_seg decoder is time-shared between the digits.
// A four-state Moore FSM rotates DIGIT0 -> BLANK0 -> DIGIT1 -> BLANK1.
// The blank states give dead time, so that one digit's anode is fully off
// before the other digit's anode turns on.
//
// Build option:
//   DISPLAY_MUX_DEADTIME_EN
//     Defined:   BLANK0 and BLANK1 last BLANK_CYCLES on every rotation.
//     Undefined: BLANK0 is skipped, so the rotation is DIGIT0 -> DIGIT1.
//                BLANK1 is only used after reset or while en=0, and it
//                lasts one cycle once released.
//
// Parameters:
//   DIGIT_CYCLES : clk cycles each digit is lit per visit (>= 2)
//   BLANK_CYCLES : clk cycles of each dead-time blank (>= 1)
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous active-high reset, forces the display dark
//   en     : display enable; when low the display is held dark in BLANK1
//   s0, s1 : hex values for digit 0 and digit 1
//   seg    : active-low segments, seg[0]=a .. seg[6]=g
//   an0    : active-low anode enable for digit 0
//   an1    : active-low anode enable for digit 1
// ---------------------------------------------------------------------------

// Hex to active-low seven-segment pattern, bit order g..a.
module seven_seg (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

module display_mux #(
    parameter int DIGIT_CYCLES = 20000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [6:0] seg,
    output logic       an0,
    output logic       an1
);

    // The counter only has to reach the longer phase length minus one.
    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
`ifdef DISPLAY_MUX_DEADTIME_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        DIGIT0 = 2'd0,
        BLANK0 = 2'd1,
        DIGIT1 = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            phase_done;
    logic            load_s0;
    logic            load_s1;
    logic [3:0]      latch;
    logic [6:0]      seg_dec;

    seven_seg decoder (
        .value (latch),
        .seg   (seg_dec)
    );

    // Next-state and phase counter.
    // A phase ends when the counter reaches its length minus one.
    // Without dead time, BLANK1 is a one-cycle exit state, so it ends at once.
    // A low en overrides everything else and parks the FSM at the start of BLANK1.
    always_comb begin
        state_next = state;
        count_next = count + CW'(1);
        phase_done = 1'b0;

        case (state)
            DIGIT0: phase_done = (count == DIGIT_LAST);
            DIGIT1: phase_done = (count == DIGIT_LAST);
`ifdef DISPLAY_MUX_DEADTIME_EN
            BLANK0: phase_done = (count == BLANK_LAST);
            BLANK1: phase_done = (count == BLANK_LAST);
`else
            BLANK0: phase_done = 1'b1;
            BLANK1: phase_done = 1'b1;
`endif
        endcase

        if (phase_done) begin
            count_next = '0;
            case (state)
`ifdef DISPLAY_MUX_DEADTIME_EN
                DIGIT0: state_next = BLANK0;
                DIGIT1: state_next = BLANK1;
`else
                DIGIT0: state_next = DIGIT1;
                DIGIT1: state_next = DIGIT0;
`endif
                BLANK0: state_next = DIGIT1;
                BLANK1: state_next = DIGIT0;
            endcase
        end

        if (!en) begin
            state_next = BLANK1;
            count_next = '0;
        end
    end

    // The latch captures a digit's value only on the edge that enters that
    // digit, so that input changes during a visit are not shown until the next visit.
    assign load_s0 = (state_next == DIGIT0) && (state != DIGIT0);
    assign load_s1 = (state_next == DIGIT1) && (state != DIGIT1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BLANK1;
            count <= '0;
            latch <= 4'h0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (load_s0) begin
                latch <= s0;
            end else if (load_s1) begin
                latch <= s1;
            end
        end
    end

    // Outputs depend only on the registered state.
    // Because of this, an0 and an1 can never both be low.
    // Because of this, an asynchronous reset also turns the display dark immediately.
    always_comb begin
        an0 = 1'b1;
        an1 = 1'b1;
        seg = 7'b1111111;
        case (state)
            DIGIT0: begin
                an0 = 1'b0;
                seg = seg_dec;
            end
            DIGIT1: begin
                an1 = 1'b0;
                seg = seg_dec;
            end
            default: begin
                an0 = 1'b1;
                an1 = 1'b1;
                seg = 7'b1111111;
            end
        endcase
    end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 20000, giving the clk cycles each digit is lit per visit (minimum 2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 200, giving the clk cycles of the dead-time blank between digits (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: display enable, sampled on clk.
REQ-006 SHALL have port s0, input, 4 bits: hex value for digit 0.
REQ-007 SHALL have port s1, input, 4 bits: hex value for digit 1.
REQ-008 SHALL have port seg, output, 7 bits: shared active-low segment bus, seg[0]=a through seg[6]=g.
REQ-009 SHALL have port an0, output, 1 bit: active-low enable for digit 0.
REQ-010 SHALL have port an1, output, 1 bit: active-low enable for digit 1.

Function
REQ-011 SHALL time-share a single seven_seg decoder instance between the two digits, with the decoder driven from one internal 4-bit latched value.
REQ-012 SHALL implement the Moore FSM states DIGIT0, BLANK0, DIGIT1, BLANK1 with the cycle order DIGIT0 -> BLANK0 -> DIGIT1 -> BLANK1 -> DIGIT0.
REQ-013 SHALL use one phase counter: cleared on every state change, incremented each cycle otherwise, and move to the next state when the count equals the phase length minus 1.
REQ-014 SHALL give DIGIT states a length of DIGIT_CYCLES and BLANK states a length of BLANK_CYCLES.
REQ-015 SHALL load the latch from s0 on the edge entering DIGIT0 and from s1 on the edge entering DIGIT1, so an s0/s1 change mid-phase has no effect until the next visit.
REQ-016 SHALL decode outputs from registered state only: in DIGIT0, an0=0 and an1=1; in DIGIT1, an0=1 and an1=0; in BLANK states, an0=an1=1 and seg=7'b1111111.
REQ-017 SHALL drive seg from the decoder output of the latch in DIGIT states.
REQ-018 SHALL, on the edge where en=0 is sampled, force state to BLANK1 with counter 0; it SHALL stay there while en=0 and resume the normal BLANK1 exit once en returns to 1.
REQ-019 SHALL never assert an0 and an1 low in the same cycle, in any state or configuration.
REQ-020 SHALL size the counter to hold max(DIGIT_CYCLES, BLANK_CYCLES)-1 and SHALL NOT let it wrap within a phase.

Reset
REQ-021 SHALL, when reset is asserted, immediately set state=BLANK1, counter=0, latch=4'h0, an0=1, an1=1, seg=7'b1111111, independent of clk.
REQ-022 SHALL, when reset is asserted mid-phase, abandon the phase with no partial-digit glitch on an0/an1.
REQ-023 SHALL, after reset deasserts with en=1, spend the BLANK1 length and then enter DIGIT0 loading s0.

Configuration
REQ-024 SHALL provide the macro DISPLAY_MUX_DEADTIME_EN; when defined, BLANK0 and BLANK1 are visited for BLANK_CYCLES on every rotation.
REQ-025 SHALL, without DISPLAY_MUX_DEADTIME_EN, skip BLANK0 and use the sequence DIGIT0 -> DIGIT1 -> DIGIT0.
REQ-026 SHALL, without DISPLAY_MUX_DEADTIME_EN, still use BLANK1 as the reset and en=0 state, lasting exactly 1 cycle after the release; REQ-019 still holds.

Verification (DIGIT_CYCLES=4, BLANK_CYCLES=2)
REQ-027 SHALL cover: macro defined, s0=4'h3, s1=4'hA, reset released -> 2 cycles dark, then 4 cycles an0=0 with seg=7'b0110000, 2 dark, then 4 cycles an1=0 with seg=7'b0001000, repeating with a period of 12.
REQ-028 SHALL cover: s0 changed from 4'h3 to 4'h8 in the 2nd cycle of DIGIT0 -> seg holds 7'b0110000 for the rest of that phase, and shows 7'b0000000 on the next DIGIT0.
REQ-029 SHALL cover: en=0 held for 5 cycles during DIGIT1 -> an0=an1=1 and seg=7'h7F from the next edge, then after en=1 returns, 2 dark cycles before DIGIT0.
REQ-030 SHALL cover: reset pulsed asynchronously between clock edges during DIGIT0 -> outputs go dark before the next edge and latch=0.
REQ-031 SHALL cover: macro undefined -> an0 low for 4 cycles then an1 low for 4 cycles with period 8, and never both low (checked every cycle over 1000 cycles).
